// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BE_W-1:0]   enable_t;
  typedef logic [2:0]        mem_size_t;

  // funct3 encodings of the access size
  localparam mem_size_t MEM_B  = 3'b000;
  localparam mem_size_t MEM_H  = 3'b001;
  localparam mem_size_t MEM_W  = 3'b010;
  localparam mem_size_t MEM_BU = 3'b100;
  localparam mem_size_t MEM_HU = 3'b101;

  // load_data_o value before the first completed load
  localparam data_t DATA_UNKNOWN = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for the LSU (purely combinational).
// Ports:
//   size_i, off_i         access size (funct3) and address bits [1:0]
//   wdata_i, rdata_i      raw store data and raw memory read word
//   be_c_o                byte enables
//   wdata_c_o             lane-replicated store data
//   rdata_c_o             shifted and sign/zero-extended load data
//   misaligned_c_o        access violates its natural alignment
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_c_o,
  output logic [31:0] wdata_c_o,
  output logic [31:0] rdata_c_o,
  output logic        misaligned_c_o
);

  data_t shifted;

  // Lane selection; unknown size codes behave like a word access.
  always_comb begin
    shifted        = rdata_i >> {off_i, 3'b000};
    be_c_o         = 4'b1111;
    wdata_c_o      = wdata_i;
    rdata_c_o      = shifted;
    misaligned_c_o = 1'b0;
    case (size_i)
      MEM_B, MEM_BU: begin
        be_c_o    = enable_t'(4'b0001 << off_i);
        wdata_c_o = {4{wdata_i[7:0]}};
        rdata_c_o = (size_i == MEM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'd0, shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        be_c_o         = enable_t'(4'b0011 << {off_i[1], 1'b0});
        wdata_c_o      = {2{wdata_i[15:0]}};
        rdata_c_o      = (size_i == MEM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'd0, shifted[15:0]};
        misaligned_c_o = off_i[0];
      end
      default: misaligned_c_o = |off_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-outstanding data-memory access with
// byte/half/word formatting and a stall toward the pipeline registers.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   alu_result_i, mem_read_c_i,
//   mem_write_c_i, mem_write_data_i,
//   mem_size_i                        EX/MEM access request
//   stall_c_o                         holds upstream pipeline registers
//   load_data_o, load_valid_o         formatted load result and its pulse
//   misalign_o                        pulse for a dropped misaligned access
//   dmem_*                            data-memory req/gnt/rvalid interface
//   timeout_o                         watchdog pulse (0 without the feature)
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [31:0]       alu_result_i,
  input  logic              mem_read_c_i,
  input  logic              mem_write_c_i,
  input  logic [31:0]       mem_write_data_i,
  input  logic [2:0]        mem_size_i,
  output logic              stall_c_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              timeout_o
);

  lsu_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  enable_t           be_q, be_d;
  data_t             wdata_q, wdata_d;
  mem_size_t         size_q, size_d;
  logic [1:0]        off_q, off_d;
  data_t             load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic              timeout_hit;

  mem_size_t         al_size;
  logic [1:0]        al_off;
  enable_t           al_be;
  data_t             al_wdata;
  data_t             al_rdata;
  logic              al_misaligned;

  // In IDLE the aligner formats the incoming request; later it formats the
  // response using the captured size and offset.
  assign al_size = (state_q == IDLE) ? mem_size_i : size_q;
  assign al_off  = (state_q == IDLE) ? alu_result_i[1:0] : off_q;

  lsu_align u_align (
    .size_i         (al_size),
    .off_i          (al_off),
    .wdata_i        (mem_write_data_i),
    .rdata_i        (dmem_rdata_i),
    .be_c_o         (al_be),
    .wdata_c_o      (al_wdata),
    .rdata_c_o      (al_rdata),
    .misaligned_c_o (al_misaligned)
  );

`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Cleared while idle (so it starts at 0 on REQ entry), counts in REQ/WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q == REQ || state_q == WAIT) &&
                       (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  // Next-state, capture and stall logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    stall_c_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_c_i || mem_write_c_i) begin
          if (al_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            stall_c_o = 1'b1;
            req_d     = 1'b1;
            we_d      = mem_write_c_i;
            addr_d    = {alu_result_i[ADDR_W-1:2], 2'b00};
            be_d      = al_be;
            wdata_d   = al_wdata;
            size_d    = mem_size_i;
            off_d     = alu_result_i[1:0];
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        stall_c_o = 1'b1;
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
        end else if (timeout_hit) begin
          req_d       = 1'b0;
          timeout_d   = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end
      end
      WAIT: begin
        stall_c_o = 1'b1;
        if (dmem_rvalid_i) begin
          load_data_d  = al_rdata;
          load_valid_d = 1'b1;
          state_d      = DONE;
        end else if (timeout_hit) begin
          timeout_d   = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      off_q        <= '0;
      load_data_q  <= DATA_UNKNOWN;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign misalign_o   = misalign_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized
// accesses checked against a transaction-level reference model.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] alu_result_i;
  logic        mem_read_c_i;
  logic        mem_write_c_i;
  logic [31:0] mem_write_data_i;
  logic [2:0]  mem_size_i;
  logic        stall_c_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        misalign_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_load;

  mem_stage_lsu dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .alu_result_i     (alu_result_i),
    .mem_read_c_i     (mem_read_c_i),
    .mem_write_c_i    (mem_write_c_i),
    .mem_write_data_i (mem_write_data_i),
    .mem_size_i       (mem_size_i),
    .stall_c_o        (stall_c_o),
    .load_data_o      (load_data_o),
    .load_valid_o     (load_valid_o),
    .misalign_o       (misalign_o),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_gnt_i       (dmem_gnt_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .timeout_o        (timeout_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access described by its byte count ----
  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'd0) return 1;
    if (s[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input int off);
    logic [7:0] m;
    m = 8'(((1 << nbytes(s)) - 1) << off);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input int off, input logic [31:0] rd);
    logic [31:0] v, mask;
    int n;
    n = nbytes(s);
    v = rd >> (8 * off);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!s[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One complete access: g cycles of grant delay, r cycles of response delay.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] sz,
                        input int g, input int r, input logic [31:0] rdata);
    int off, stall_cnt, exp_stall;
    bit is_load, mis;
    off       = int'(addr[1:0]);
    is_load   = rd && !wr;
    mis       = (off % nbytes(sz)) != 0;
    stall_cnt = 0;

    @(negedge ACLK);
    mem_read_c_i = rd; mem_write_c_i = wr; alu_result_i = addr;
    mem_write_data_i = wd; mem_size_i = sz;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    chk("idle_stall", 32'(stall_c_o), 32'(!mis));
    stall_cnt += int'(stall_c_o);

    if (mis) begin
      @(negedge ACLK);
      mem_read_c_i = 1'b0; mem_write_c_i = 1'b0;
      #1;
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_noreq", 32'(dmem_req_o), 32'd0);
      chk("mis_stall", 32'(stall_c_o), 32'd0);
      @(negedge ACLK);
      #1;
      chk("mis_clear", 32'(misalign_o), 32'd0);
      chk("mis_noreq2", 32'(dmem_req_o), 32'd0);
      chk("mis_ldhold", load_data_o, last_load);
      return;
    end

    for (int c = 0; c <= g; c++) begin
      @(negedge ACLK);
      dmem_gnt_i    = (c == g);
      dmem_rvalid_i = 1'($urandom_range(0, 1));   // responses before grant are ignored
      dmem_rdata_i  = $urandom;
      #1;
      chk("req", 32'(dmem_req_o), 32'd1);
      chk("we", 32'(dmem_we_o), 32'(wr));
      chk("addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
      chk("be", 32'(dmem_be_o), 32'(m_be(sz, off)));
      if (wr) chk("wdata", dmem_wdata_o, m_wdata(sz, wd));
      chk("req_stall", 32'(stall_c_o), 32'd1);
      chk("req_lvalid", 32'(load_valid_o), 32'd0);
      stall_cnt += int'(stall_c_o);
    end

    if (is_load) begin
      for (int c = 0; c <= r; c++) begin
        @(negedge ACLK);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = (c == r);
        dmem_rdata_i  = (c == r) ? rdata : $urandom;
        #1;
        chk("wait_noreq", 32'(dmem_req_o), 32'd0);
        stall_cnt += int'(stall_c_o);
      end
      last_load = m_load(sz, off, rdata);
    end

    @(negedge ACLK);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    mem_read_c_i = 1'b0; mem_write_c_i = 1'b0;
    #1;
    exp_stall = is_load ? (g + r + 3) : (g + 2);
    chk("done_stall", 32'(stall_c_o), 32'd0);
    chk("done_lvalid", 32'(load_valid_o), 32'(is_load));
    chk("done_ldata", load_data_o, last_load);
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("done_timeout", 32'(timeout_o), 32'd0);

    @(negedge ACLK);
    #1;
    chk("post_lvalid", 32'(load_valid_o), 32'd0);
    chk("post_ldata", load_data_o, last_load);
    chk("post_noreq", 32'(dmem_req_o), 32'd0);
  endtask

  logic [2:0] sizes [5];
  logic       r_rd, r_wr;

  initial begin
    sizes = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
    ARESET = 1'b1;
    alu_result_i = '0; mem_read_c_i = 1'b0; mem_write_c_i = 1'b0;
    mem_write_data_i = '0; mem_size_i = MEM_W;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    last_load = DATA_UNKNOWN;

    repeat (2) @(negedge ACLK);
    #1;
    chk("rst_stall", 32'(stall_c_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_lvalid", 32'(load_valid_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_ldata", load_data_o, DATA_UNKNOWN);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Directed cases
    run_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, MEM_W, 0, 0, 32'h0);
    run_op(1'b1, 1'b0, 32'h103, 32'h0, MEM_B, 0, 2, 32'h80112233);
    chk("lb_value", load_data_o, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 32'h103, 32'h0, MEM_BU, 0, 2, 32'h80112233);
    chk("lbu_value", load_data_o, 32'h00000080);
    run_op(1'b0, 1'b1, 32'h102, 32'h0000ABCD, MEM_H, 3, 0, 32'h0);
    run_op(1'b1, 1'b0, 32'h101, 32'h0, MEM_W, 0, 0, 32'h0);
    run_op(1'b1, 1'b1, 32'h201, 32'h12345678, MEM_HU, 1, 0, 32'h0);

    // Reset while waiting for a response; the late response must be ignored
    @(negedge ACLK);
    mem_read_c_i = 1'b1; alu_result_i = 32'h200; mem_size_i = MEM_W;
    #1;
    chk("rw_idle_stall", 32'(stall_c_o), 32'd1);
    @(negedge ACLK);
    dmem_gnt_i = 1'b1;
    #1;
    chk("rw_req", 32'(dmem_req_o), 32'd1);
    @(negedge ACLK);
    dmem_gnt_i = 1'b0; mem_read_c_i = 1'b0; ARESET = 1'b1;
    #1;
    chk("rw_wait_stall", 32'(stall_c_o), 32'd1);
    @(negedge ACLK);
    ARESET = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("rw_stall", 32'(stall_c_o), 32'd0);
    chk("rw_req0", 32'(dmem_req_o), 32'd0);
    chk("rw_ldata", load_data_o, DATA_UNKNOWN);
    @(negedge ACLK);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rw_lvalid", 32'(load_valid_o), 32'd0);
    chk("rw_stall2", 32'(stall_c_o), 32'd0);
    chk("rw_ldata2", load_data_o, DATA_UNKNOWN);
    last_load = DATA_UNKNOWN;

    // Randomized accesses
    for (int k = 0; k < 60; k++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      run_op(r_rd, r_wr, $urandom, $urandom, sizes[$urandom_range(0, 4)],
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
